// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - command, ALU and response signal bundle for alu_cmd_sequencer
interface alu_cmd_sequencer_if #(
   parameter int WIDTH = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic             cmd_load;
   logic [WIDTH-1:0] cmd_data;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_op;
   logic             alu_c_in;
   logic [WIDTH-1:0] alu_out;
   logic             alu_c_out;
   logic             alu_c_flag;
   logic             alu_zero;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic             res_carry;
   logic             res_zero;
   logic             res_gt;
   logic             busy;

   modport slave (
      input  cmd_valid, cmd_op, cmd_load, cmd_data,
      input  alu_out, alu_c_out, alu_c_flag, alu_zero, res_ready,
      output cmd_ready, alu_a, alu_b, alu_op, alu_c_in,
      output res_valid, res_data, res_carry, res_zero, res_gt, busy
   );

   modport master (
      output cmd_valid, cmd_op, cmd_load, cmd_data,
      output alu_out, alu_c_out, alu_c_flag, alu_zero, res_ready,
      input  cmd_ready, alu_a, alu_b, alu_op, alu_c_in,
      input  res_valid, res_data, res_carry, res_zero, res_gt, busy
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - accumulator command sequencer in front of a combinational 8-bit ALU
module alu_cmd_sequencer #(
   parameter int               WIDTH       = 8,
   parameter int               EXEC_CYCLES = 1,
   parameter logic [WIDTH-1:0] ACC_RESET   = '0
) (
   input logic                clk,
   input logic                rst_n,
   alu_cmd_sequencer_if.slave io
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] b_reg;
   logic [2:0]       op_reg;
   logic [3:0]       cnt;
   logic             cmd_ready_r;
   logic             res_valid_r;
   logic [WIDTH-1:0] res_data_r;
   logic             res_carry_r;
   logic             res_zero_r;
   logic             res_gt_r;
   logic             busy_r;
   logic             exec_carry;

   // Shift ops report the bit shifted out, taken from the pre-update operands.
   always_comb begin
      exec_carry = 1'b0;
      case (op_reg)
         3'b000, 3'b001: exec_carry = io.alu_c_out;
         3'b110:         exec_carry = acc[WIDTH-1];
         3'b111:         exec_carry = b_reg[WIDTH-1];
         default:        exec_carry = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         acc         <= ACC_RESET;
         b_reg       <= '0;
         op_reg      <= '0;
         cnt         <= '0;
         cmd_ready_r <= 1'b1;
         res_valid_r <= 1'b0;
         res_data_r  <= '0;
         res_carry_r <= 1'b0;
         res_zero_r  <= 1'b0;
         res_gt_r    <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (io.cmd_valid && cmd_ready_r) begin
                  op_reg      <= io.cmd_op;
                  b_reg       <= io.cmd_data;
                  cmd_ready_r <= 1'b0;
                  busy_r      <= 1'b1;
                  if (io.cmd_load) begin
                     acc         <= io.cmd_data;
                     res_data_r  <= io.cmd_data;
                     res_carry_r <= 1'b0;
                     res_gt_r    <= 1'b0;
                     res_zero_r  <= (io.cmd_data == '0);
                     res_valid_r <= 1'b1;
                     state       <= RESP;
                  end else begin
                     cnt   <= 4'(EXEC_CYCLES - 1);
                     state <= EXEC;
                  end
               end
            end
            EXEC: begin
               if (cnt == 4'd0) begin
                  res_data_r  <= io.alu_out;
                  res_zero_r  <= io.alu_zero;
                  res_gt_r    <= io.alu_c_flag;
                  res_carry_r <= exec_carry;
                  res_valid_r <= 1'b1;
                  if (op_reg != 3'b101)
                     acc <= io.alu_out;
                  state <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (io.res_ready) begin
                  res_valid_r <= 1'b0;
                  cmd_ready_r <= 1'b1;
                  busy_r      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign io.cmd_ready = cmd_ready_r;
   assign io.alu_a     = acc;
   assign io.alu_b     = b_reg;
   assign io.alu_op    = op_reg;
   assign io.alu_c_in  = (op_reg == 3'b001);
   assign io.res_valid = res_valid_r;
   assign io.res_data  = res_data_r;
   assign io.res_carry = res_carry_r;
   assign io.res_zero  = res_zero_r;
   assign io.res_gt    = res_gt_r;
   assign io.busy      = busy_r;
endmodule
